// File: rtl/vme_regbank_if.sv
// vme_regbank_if -- register-bank access bus.
//
// Strobe/ack protocol (one comment for the whole bus): rd_mem and wr_mem are
// single-cycle request strobes with no back-pressure. The bank accepts every
// strobe on the rising edge that samples it. It answers each accepted request
// with exactly one rd_done or wr_done pulse, in issue order. err pulses in the
// same cycle as the ack of any request that had no effect: an unmapped
// address, or a write to a read-only register.
//
// Signals:
//   addr     word address, shared by reads and writes
//   wr_data  32-bit write data; bits above the register width are ignored
//   rd_mem   read strobe
//   wr_mem   write strobe
//   rd_data  32-bit read data, zero-extended from the register width
//   rd_done  read acknowledge pulse
//   wr_done  write acknowledge pulse
//   err      pulse that accompanies the ack of an access with no effect
interface vme_regbank_if #(
  parameter int AW = 2
) ();
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic          rd_mem;
  logic          wr_mem;
  logic [31:0]   rd_data;
  logic          rd_done;
  logic          wr_done;
  logic          err;

  modport master (
    output addr, wr_data, rd_mem, wr_mem,
    input  rd_data, rd_done, wr_done, err
  );

  modport slave (
    input  addr, wr_data, rd_mem, wr_mem,
    output rd_data, rd_done, wr_done, err
  );
endinterface

// File: rtl/vme_regbank.sv
// vme_regbank -- small parameterised control/status register bank.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   bus         vme_regbank_if slave: addr, wr_data, rd_mem, wr_mem in;
//               rd_data, rd_done, wr_done, err out
//   regs_o      current values of the RW registers (RO slices read as 0)
//   regs_i      read-back sources for the RO registers
//   wr_pulse_o  one-cycle pulse per register, in the cycle its new value shows
//
// Timing (cycle 0 = the cycle in which a strobe is high):
//   write: the register value, wr_pulse_o, wr_done and err all change together,
//          in cycle 1+PIPE_WR.
//   read:  rd_done, rd_data and err appear in cycle PIPE_RD.
// A read always returns the value left by every earlier write. It never sees a
// write issued in the same cycle. With PIPE_WR=1, a write that is still in the
// input stage is forwarded to the read path so that this order holds.
module vme_regbank #(
  parameter int                      NREGS     = 4,
  parameter int                      DATA_W    = 16,
  parameter int                      AW        = 2,
  parameter logic [NREGS-1:0]        RO_MASK   = '0,
  parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0,
  parameter int                      PIPE_WR   = 1,
  parameter int                      PIPE_RD   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vme_regbank_if.slave            bus,
  output logic [NREGS*DATA_W-1:0] regs_o,
  input  logic [NREGS*DATA_W-1:0] regs_i,
  output logic [NREGS-1:0]        wr_pulse_o
);

  // The address decode covers every address value, so no lookup goes out of range.
  localparam int NSLOT = 1 << AW;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [NSLOT-1:0]  slot_mapped;
  logic [NSLOT-1:0]  slot_wr_ok;
  logic [DATA_W-1:0] rd_view [NSLOT];

  // Write stage outputs (registered or direct, depending on PIPE_WR).
  logic              wr_v_s;
  logic [AW-1:0]     wr_a_s;
  logic [DATA_W-1:0] wr_d_s;

  logic wr_done_q;
  logic wr_err_q;
  logic rd_err;

  // The upper write-data bits and the regs_i slices of RW registers are
  // deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.wr_data, regs_i};

  // ---------------------------------------------------------------------------
  // Write input stage
  // ---------------------------------------------------------------------------
  if (PIPE_WR != 0) begin : g_wr_pipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_v_s <= 1'b0;
        wr_a_s <= '0;
        wr_d_s <= '0;
      end else begin
        wr_v_s <= bus.wr_mem;
        wr_a_s <= bus.addr;
        wr_d_s <= bus.wr_data[DATA_W-1:0];
      end
    end
  end else begin : g_wr_direct
    assign wr_v_s = bus.wr_mem;
    assign wr_a_s = bus.addr;
    assign wr_d_s = bus.wr_data[DATA_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Per-address decode and read view
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NREGS) begin : g_map
      logic [DATA_W-1:0] rw_val;
      // Forward a write that sits in the input stage. The register only takes
      // this value on the next edge, and a later read must already see it.
      assign rw_val = ((PIPE_WR != 0) && wr_v_s && (wr_a_s == AW'(g)))
                      ? wr_d_s : regs_q[g];
      assign slot_mapped[g] = 1'b1;
      assign slot_wr_ok[g]  = ~RO_MASK[g];
      assign rd_view[g]     = RO_MASK[g] ? regs_i[g*DATA_W +: DATA_W] : rw_val;
    end else begin : g_unmap
      assign slot_mapped[g] = 1'b0;
      assign slot_wr_ok[g]  = 1'b0;
      assign rd_view[g]     = '0;
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_regs_o
    assign regs_o[r*DATA_W +: DATA_W] = RO_MASK[r] ? '0 : regs_q[r];
  end

  // ---------------------------------------------------------------------------
  // Write commit: the register, its pulse and the ack all update on the same edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
      wr_pulse_o <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_done_q <= wr_v_s;
      wr_err_q  <= wr_v_s & ~slot_wr_ok[wr_a_s];
      for (int i = 0; i < NREGS; i++) begin
        if (wr_v_s && slot_wr_ok[i] && (wr_a_s == AW'(i))) begin
          regs_q[i]     <= wr_d_s;
          wr_pulse_o[i] <= 1'b1;
        end else begin
          wr_pulse_o[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.wr_done = wr_done_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  assign rd_word = 32'(rd_view[bus.addr]);

  if (PIPE_RD != 0) begin : g_rd_pipe
    logic [31:0] rd_data_q;
    logic        rd_done_q;
    logic        rd_err_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q <= '0;
        rd_done_q <= 1'b0;
        rd_err_q  <= 1'b0;
      end else begin
        rd_data_q <= bus.rd_mem ? rd_word : '0;
        rd_done_q <= bus.rd_mem;
        rd_err_q  <= bus.rd_mem & ~slot_mapped[bus.addr];
      end
    end
    assign bus.rd_data = rd_data_q;
    assign bus.rd_done = rd_done_q;
    assign rd_err      = rd_err_q;
  end else begin : g_rd_direct
    // The combinational path is gated by rst_n, so it stays quiet in reset.
    assign bus.rd_data = (rst_n && bus.rd_mem) ? rd_word : '0;
    assign bus.rd_done = rst_n & bus.rd_mem;
    assign rd_err      = rst_n & bus.rd_mem & ~slot_mapped[bus.addr];
  end

  assign bus.err = rd_err | wr_err_q;

endmodule

// File: tb/tb_vme_regbank.sv
// tb_vme_regbank -- directed bench for vme_regbank.
// dut_a: 4 RW registers, both pipeline stages, reset value 0x00A5 in register 2.
// dut_b: 3 registers with register 2 read-only, no pipeline stages, address 3 unmapped.
module tb_vme_regbank;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_assert;
  int   n_fail;

  vme_regbank_if #(.AW(2)) bus_a ();
  vme_regbank_if #(.AW(2)) bus_b ();

  logic [63:0] regs_o_a;
  logic [63:0] regs_i_a;
  logic [3:0]  pulse_a;
  logic [47:0] regs_o_b;
  logic [47:0] regs_i_b;
  logic [2:0]  pulse_b;

  vme_regbank #(
    .NREGS(4), .DATA_W(16), .AW(2), .RO_MASK(4'b0000),
    .RESET_VAL(64'h0000_00A5_0000_0000), .PIPE_WR(1), .PIPE_RD(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .regs_o(regs_o_a), .regs_i(regs_i_a), .wr_pulse_o(pulse_a)
  );

  vme_regbank #(
    .NREGS(3), .DATA_W(16), .AW(2), .RO_MASK(3'b100),
    .RESET_VAL(48'hBEEF_0000_0007), .PIPE_WR(0), .PIPE_RD(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .regs_o(regs_o_b), .regs_i(regs_i_b), .wr_pulse_o(pulse_b)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  // Read entries: {err, data32}. Write entries: {ok, err, addr, data16}.
  // The *_t* queues hold the cycle number in which each ack is due.
  logic [32:0] rd_qa[$];
  logic [32:0] rd_qb[$];
  logic [19:0] wr_qa[$];
  logic [19:0] wr_qb[$];
  int          rd_ta[$];
  int          wr_ta[$];
  int          rd_tb[$];
  int          wr_tb[$];
  logic [15:0] arch_a[4];   // value order at issue time
  logic [15:0] shad_a[4];   // value that regs_o should show now
  logic [15:0] arch_b[3];
  logic [15:0] shad_b[3];
  localparam logic [15:0] RO_B2 = 16'h5A5A;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic reset_models();
    shad_a[0] = 16'h0000; shad_a[1] = 16'h0000; shad_a[2] = 16'h00A5; shad_a[3] = 16'h0000;
    shad_b[0] = 16'h0007; shad_b[1] = 16'h0000; shad_b[2] = 16'h0000;
    for (int i = 0; i < 4; i++) arch_a[i] = shad_a[i];
    for (int i = 0; i < 3; i++) arch_b[i] = shad_b[i];
  endtask

  function automatic int pending();
    return rd_qa.size() + wr_qa.size() + rd_qb.size() + wr_qb.size();
  endfunction

  // ---------------------------------------------------------------- monitors
  logic [32:0] mr_a, mr_b;
  logic [19:0] mw_a, mw_b;
  logic        me_a, me_b;
  logic [3:0]  mp_a;
  logic [2:0]  mp_b;
  int          mt_a, mt_b;

  always @(negedge clk) begin
    me_a = 1'b0;
    mp_a = '0;
    if (bus_a.rd_done) begin
      chk("a_rd_pending", 64'(rd_qa.size() != 0), 64'd1);
      if (rd_qa.size() != 0) begin
        mr_a = rd_qa.pop_front();
        mt_a = rd_ta.pop_front();
        chk("a_rd_data", 64'(bus_a.rd_data), 64'(mr_a[31:0]));
        chk("a_rd_latency", 64'(cyc), 64'(mt_a));
        me_a = me_a | mr_a[32];
      end
    end
    if (bus_a.wr_done) begin
      chk("a_wr_pending", 64'(wr_qa.size() != 0), 64'd1);
      if (wr_qa.size() != 0) begin
        mw_a = wr_qa.pop_front();
        mt_a = wr_ta.pop_front();
        chk("a_wr_latency", 64'(cyc), 64'(mt_a));
        me_a = me_a | mw_a[18];
        if (mw_a[19]) begin
          mp_a[mw_a[17:16]]   = 1'b1;
          shad_a[mw_a[17:16]] = mw_a[15:0];
        end
      end
    end
    chk("a_wr_pulse", 64'(pulse_a), 64'(mp_a));
    chk("a_err", 64'(bus_a.err), 64'(me_a));
    chk("a_regs_o", regs_o_a, {shad_a[3], shad_a[2], shad_a[1], shad_a[0]});
  end

  always @(negedge clk) begin
    me_b = 1'b0;
    mp_b = '0;
    if (bus_b.rd_done) begin
      chk("b_rd_pending", 64'(rd_qb.size() != 0), 64'd1);
      if (rd_qb.size() != 0) begin
        mr_b = rd_qb.pop_front();
        mt_b = rd_tb.pop_front();
        chk("b_rd_data", 64'(bus_b.rd_data), 64'(mr_b[31:0]));
        chk("b_rd_latency", 64'(cyc), 64'(mt_b));
        me_b = me_b | mr_b[32];
      end
    end
    if (bus_b.wr_done) begin
      chk("b_wr_pending", 64'(wr_qb.size() != 0), 64'd1);
      if (wr_qb.size() != 0) begin
        mw_b = wr_qb.pop_front();
        mt_b = wr_tb.pop_front();
        chk("b_wr_latency", 64'(cyc), 64'(mt_b));
        me_b = me_b | mw_b[18];
        if (mw_b[19]) begin
          mp_b[mw_b[17:16]]   = 1'b1;
          shad_b[mw_b[17:16]] = mw_b[15:0];
        end
      end
    end
    chk("b_wr_pulse", 64'(pulse_b), 64'(mp_b));
    chk("b_err", 64'(bus_b.err), 64'(me_b));
    chk("b_regs_o", 64'(regs_o_b), 64'({16'h0000, shad_b[1], shad_b[0]}));
  end

  // ---------------------------------------------------------------- drivers
  task automatic op_a(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] d);
    bus_a.rd_mem  = rd;
    bus_a.wr_mem  = wr;
    bus_a.addr    = a;
    bus_a.wr_data = d;
    if (rd) begin
      rd_qa.push_back({1'b0, 16'h0000, arch_a[a]});
      rd_ta.push_back(cyc + 1);
    end
    if (wr) begin
      wr_qa.push_back({1'b1, 1'b0, a, d[15:0]});
      wr_ta.push_back(cyc + 2);
      arch_a[a] = d[15:0];
    end
    @(posedge clk); #1;
    bus_a.rd_mem = 1'b0;
    bus_a.wr_mem = 1'b0;
  endtask

  task automatic op_b(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] d);
    logic ok;
    bus_b.rd_mem  = rd;
    bus_b.wr_mem  = wr;
    bus_b.addr    = a;
    bus_b.wr_data = d;
    if (rd) begin
      if (a == 2'd3)      rd_qb.push_back({1'b1, 32'h0000_0000});
      else if (a == 2'd2) rd_qb.push_back({1'b0, 16'h0000, RO_B2});
      else                rd_qb.push_back({1'b0, 16'h0000, arch_b[a]});
      rd_tb.push_back(cyc);
    end
    if (wr) begin
      ok = (a < 2'd2);
      wr_qb.push_back({ok, ~ok, a, d[15:0]});
      wr_tb.push_back(cyc + 1);
      if (ok) arch_b[a] = d[15:0];
    end
    @(posedge clk); #1;
    bus_b.rd_mem = 1'b0;
    bus_b.wr_mem = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pending() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_outstanding", 64'(pending()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    cyc = 0; n_assert = 0; n_fail = 0;
    rst_n = 1'b0;
    bus_a.addr = '0; bus_a.wr_data = '0; bus_a.rd_mem = 1'b0; bus_a.wr_mem = 1'b0;
    bus_b.addr = '0; bus_b.wr_data = '0; bus_b.rd_mem = 1'b1; bus_b.wr_mem = 1'b0;
    regs_i_a = 64'hFFFF_FFFF_FFFF_FFFF;
    regs_i_b = {RO_B2, 16'h1111, 16'hFFFF};
    reset_models();

    // Reset: outputs quiet, reset values visible; dut_b has a read held high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_regs_o", regs_o_a, 64'h0000_00A5_0000_0000);
    chk("rst_a_rd_data", 64'(bus_a.rd_data), 64'd0);
    chk("rst_a_acks", 64'({bus_a.rd_done, bus_a.wr_done, bus_a.err}), 64'd0);
    chk("rst_a_pulse", 64'(pulse_a), 64'd0);
    chk("rst_b_rd_data", 64'(bus_b.rd_data), 64'd0);
    chk("rst_b_acks", 64'({bus_b.rd_done, bus_b.wr_done, bus_b.err}), 64'd0);
    chk("rst_b_regs_o", 64'(regs_o_b), 64'h0000_0000_0007);
    bus_b.rd_mem = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // The first strobe goes in right after reset is released; the value is read back later.
    op_a(0, 1, 2'd1, 32'hDEAD_1234);
    op_a(0, 0, 2'd0, 32'h0);
    op_a(0, 0, 2'd0, 32'h0);
    op_a(1, 0, 2'd1, 32'h0);
    drain();

    // Back-to-back writes to all registers, then back-to-back reads.
    for (int i = 0; i < 4; i++) op_a(0, 1, 2'(i), $urandom());
    for (int i = 0; i < 4; i++) op_a(1, 0, 2'(i), 32'h0);
    drain();

    // Same-cycle read and write: the read sees the old value and the next read sees the new one.
    op_a(0, 1, 2'd0, 32'h0000_0011);
    drain();
    op_a(1, 1, 2'd0, 32'h0000_0022);
    op_a(1, 0, 2'd0, 32'h0);
    drain();

    // Random mix on the pipelined bank.
    for (int i = 0; i < 30; i++)
      op_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom());
    drain();

    // Unpipelined bank: RO write, RO read, unmapped read and write, RW traffic.
    op_b(0, 1, 2'd2, 32'h1234_FFFF);
    op_b(1, 0, 2'd2, 32'h0);
    op_b(1, 0, 2'd3, 32'h0);
    op_b(0, 1, 2'd3, 32'h0000_9999);
    op_b(0, 1, 2'd0, 32'hABCD_0042);
    op_b(1, 0, 2'd0, 32'h0);
    op_b(1, 1, 2'd1, 32'h0000_0077);
    op_b(1, 0, 2'd1, 32'h0);
    for (int i = 0; i < 20; i++)
      op_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom());
    drain();

    // Reset while a write is still in dut_a's input stage: it must never be acked.
    bus_a.addr = 2'd3; bus_a.wr_data = 32'h0000_BEEF; bus_a.wr_mem = 1'b1;
    @(posedge clk); #1;
    bus_a.wr_mem = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("inflight_a_regs_o", regs_o_a, 64'h0000_00A5_0000_0000);

    // The bank works normally after reset.
    op_a(0, 1, 2'd3, 32'h0000_C0DE);
    op_a(1, 0, 2'd3, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vme_regbank.md
VME_REGBANK -- requirements
Module: vme_regbank

Interface
REQ-001 Parameter NREGS, default 4, number of registers; 1..64.
REQ-002 Parameter DATA_W, default 16, register width in bits; 1..32.
REQ-003 Parameter AW, default 2, word-address width; AW SHALL satisfy 2**AW >= NREGS.
REQ-004 Parameter RO_MASK, default all zeros, NREGS bits; bit i=1 makes register i read-only.
REQ-005 Parameter RESET_VAL, default all zeros, NREGS*DATA_W bits; slice i is the reset value of register i.
REQ-006 Parameter PIPE_WR, default 1, 0/1; adds one input stage on the write path.
REQ-007 Parameter PIPE_RD, default 1, 0/1; adds one output stage on the read path.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  reset; synchronous, active-low.
REQ-010 addr  in  AW  word address, shared by read and write.
REQ-011 wr_data  in  32  write data; bits above DATA_W are ignored.
REQ-012 rd_mem  in  1  single-cycle read strobe.
REQ-013 wr_mem  in  1  single-cycle write strobe.
REQ-014 rd_data  out  32  read data.
REQ-015 rd_done  out  1  read acknowledge, one-cycle pulse.
REQ-016 wr_done  out  1  write acknowledge, one-cycle pulse.
REQ-017 err  out  1  one-cycle pulse marking an access that was acked but had no effect.
REQ-018 regs_o  out  NREGS*DATA_W  current values of the RW registers; slice i = register i.
REQ-019 regs_i  in  NREGS*DATA_W  read-back sources for the RO registers; slice i is used only when RO_MASK[i]=1.
REQ-020 wr_pulse_o  out  NREGS  one-cycle pulse on the cycle in which register i is updated.

Function
REQ-021 Write path: wr_mem, addr and wr_data SHALL be registered once when PIPE_WR=1, and used directly when PIPE_WR=0.
REQ-022 The write SHALL update its register PIPE_WR cycles after the edge that samples wr_mem; wr_pulse_o[addr] SHALL be high for that same one cycle.
REQ-023 wr_done SHALL pulse exactly once, 1+PIPE_WR cycles after wr_mem is sampled (registered ack).
REQ-024 Read path: rd_done and rd_data SHALL be combinational from rd_mem when PIPE_RD=0, and registered once (1-cycle latency) when PIPE_RD=1.
REQ-025 Read data SHALL carry the register value in bits [DATA_W-1:0], with all higher bits 0 (never X).
REQ-026 RO registers SHALL read regs_i; RW registers SHALL read their stored value.
REQ-027 Unmapped address (addr >= NREGS): the write SHALL be acked with no register change and no wr_pulse_o; the read SHALL return 0 and be acked. err SHALL pulse together with the ack in both cases.
REQ-028 A write to an RO register SHALL be acked with no change and no wr_pulse_o; err SHALL pulse with wr_done.
REQ-029 If rd_mem and wr_mem are both high in one cycle, both SHALL be serviced; the read SHALL return the pre-write value.
REQ-030 Strobes arriving on consecutive cycles SHALL each be acked exactly once and in order; no request SHALL be dropped or merged (throughput 1 per cycle).
REQ-031 regs_o slices of RO registers SHALL be driven to 0.

Reset
REQ-032 While rst_n=0: RW registers SHALL load RESET_VAL; rd_data=0; rd_done, wr_done, err and wr_pulse_o SHALL be 0; all pipeline stages SHALL be cleared.
REQ-033 A write that is in the pipeline when reset asserts SHALL be discarded and never acked.
REQ-034 The first strobe SHALL be accepted on the first edge after rst_n returns to 1.

Verification
REQ-035 Reset: NREGS=4, RESET_VAL slice 2=0x00A5 -> regs_o slice 2=0x00A5; all outputs 0.
REQ-036 Write/read, PIPE_WR=1, PIPE_RD=1: write 0xDEAD1234 to addr 1 -> reg1=0x1234 after 1 cycle; wr_done on cycle 2; a later read of addr 1 -> rd_data=0x00001234 with rd_done 1 cycle after rd_mem.
REQ-037 Back-to-back writes to addr 0,1,2,3 on 4 consecutive cycles -> 4 wr_done pulses and 4 wr_pulse_o pulses, one per register in order; all values correct.
REQ-038 RO_MASK=0b0100, regs_i slice 2=0x5A5A: write to addr 2 -> err and wr_done, no wr_pulse_o; read addr 2 -> 0x00005A5A.
REQ-039 NREGS=3, AW=2: read addr 3 -> rd_data=0, rd_done and err; write addr 3 -> wr_done and err, no register change.
REQ-040 Simultaneous rd_mem+wr_mem to addr 0 (old value 0x0011, new 0x0022) -> read returns 0x0011; a following read returns 0x0022. Then assert rst_n=0 while a write is in flight -> no wr_done.
